// File: rtl/game_pkg.sv
// Shared types and defaults for the player-vs-PC game blocks.
//   timer_state_t        : turn timer states (IDLE, RUN, DONE), 2-bit encoding
//   DEFAULT_TURN_SECONDS : default turn length in seconds
//   DEFAULT_CLK_HZ       : default system clock frequency (cycles per second)
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  localparam int unsigned DEFAULT_TURN_SECONDS = 15;
  localparam int unsigned DEFAULT_CLK_HZ       = 50_000_000;

endpackage

// File: rtl/turn_timer_tick_gen.sv
// Prescaler for the turn timer: divides the system clock down to a
// one-cycle tick per CLK_HZ enabled cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset, zeroes the count
//   clr  : synchronous clear, zeroes the count
//   en   : count enable
//   tick : high for one cycle when the count is at CLK_HZ-1 while en=1
module tick_gen
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRE_W-1:0] TERM = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] count;

  assign tick = en && (count == TERM);

  // Wraps at CLK_HZ-1, so the PRE_W-bit counter never overflows.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown timer feeding the game turn FSM.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   start     : level from FSM, loads and starts the count from IDLE
//   move_done : player committed a move, stops the count without timeout
//   timeout   : registered one-cycle pulse when the count expires
//   running   : high while counting (state RUN)
//   secs_left : remaining whole seconds, binary
//   bcd_tens  : tens digit of secs_left
//   bcd_ones  : ones digit of secs_left
module turn_timer
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int unsigned TURN_SECONDS = DEFAULT_TURN_SECONDS,
  parameter int unsigned PRE_W        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_done,
  output logic       timeout,
  output logic       running,
  output logic [6:0] secs_left,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
);

  timer_state_t state_q, state_d;
  logic [6:0]   secs_q, secs_d;
  logic         timeout_q, timeout_d;
  logic         tick;
  logic         pre_en;
  logic         pre_clr;
  logic [6:0]   rem;

  // Prescaler is held at zero outside RUN so the first tick lands exactly
  // CLK_HZ cycles after the load edge; move_done also clears it.
  assign pre_en  = (state_q == RUN);
  assign pre_clr = (state_q != RUN) || move_done;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .PRE_W  (PRE_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      secs_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    secs_d    = secs_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          secs_d  = 7'(TURN_SECONDS);
        end
      end
      RUN: begin
        // move_done outranks the final tick: the player beat the clock.
        if (move_done) begin
          state_d = IDLE;
        end else if (tick) begin
          if (secs_q == 7'd1) begin
            secs_d    = '0;
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            secs_d = secs_q - 7'd1;
          end
        end
      end
      DONE: begin
        // Held while start stays high so a level-held start cannot retrigger.
        secs_d = '0;
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Binary to two-digit BCD by compare-subtract on weights 80/40/20/10.
  always_comb begin
    rem      = secs_q;
    bcd_tens = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (rem >= 7'(10 << (3 - i))) begin
        rem               = rem - 7'(10 << (3 - i));
        bcd_tens[3 - i]   = 1'b1;
      end
    end
    bcd_ones = rem[3:0];
  end

  assign timeout   = timeout_q;
  assign running   = (state_q == RUN);
  assign secs_left = secs_q;

endmodule

// File: tb/tb_turn_timer.sv
module tb_turn_timer;

  localparam int HZ_A = 4;
  localparam int TS_A = 15;
  localparam int HZ_B = 2;
  localparam int TS_B = 99;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, start_a = 1'b0, md_a = 1'b0;
  logic       rst_b = 1'b1, start_b = 1'b0, md_b = 1'b0;
  logic       to_a, run_a, to_b, run_b;
  logic [6:0] secs_a, secs_b;
  logic [3:0] tens_a, ones_a, tens_b, ones_b;

  turn_timer #(.CLK_HZ(HZ_A), .TURN_SECONDS(TS_A)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .move_done(md_a),
    .timeout(to_a), .running(run_a), .secs_left(secs_a),
    .bcd_tens(tens_a), .bcd_ones(ones_a)
  );

  turn_timer #(.CLK_HZ(HZ_B), .TURN_SECONDS(TS_B)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .move_done(md_b),
    .timeout(to_b), .running(run_b), .secs_left(secs_b),
    .bcd_tens(tens_b), .bcd_ones(ones_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a turn is "in progress" for TS*HZ cycles after load;
  // remaining seconds follow from elapsed cycles by plain division.
  // phase: 0 idle, 1 counting, 2 expired-waiting-for-start-low
  int m_phase[2], m_el[2], m_secs[2], m_to[2];
  int p_hz[2] = '{HZ_A, HZ_B};
  int p_ts[2] = '{TS_A, TS_B};
  int to_seen_a = 0;

  function automatic void model_step(input int k, input bit r, input bit s, input bit md);
    m_to[k] = 0;
    if (r) begin
      m_phase[k] = 0; m_secs[k] = 0;
    end else if (m_phase[k] == 0) begin
      if (s) begin
        m_phase[k] = 1; m_el[k] = 0; m_secs[k] = p_ts[k];
      end
    end else if (m_phase[k] == 1) begin
      if (md) begin
        m_phase[k] = 0;
      end else begin
        m_el[k]++;
        if (m_el[k] == p_ts[k] * p_hz[k]) begin
          m_phase[k] = 2; m_secs[k] = 0; m_to[k] = 1;
        end else begin
          m_secs[k] = p_ts[k] - m_el[k] / p_hz[k];
        end
      end
    end else begin
      if (!s) m_phase[k] = 0;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step(0, rst_a, start_a, md_a);
    model_step(1, rst_b, start_b, md_b);
    if (to_a) to_seen_a++;
    check("a_running", int'(run_a), int'(m_phase[0] == 1));
    check("a_timeout", int'(to_a), m_to[0]);
    check("a_secs", int'(secs_a), m_secs[0]);
    check("a_tens", int'(tens_a), m_secs[0] / 10);
    check("a_ones", int'(ones_a), m_secs[0] % 10);
    check("b_running", int'(run_b), int'(m_phase[1] == 1));
    check("b_timeout", int'(to_b), m_to[1]);
    check("b_secs", int'(secs_b), m_secs[1]);
    check("b_tens", int'(tens_b), m_secs[1] / 10);
    check("b_ones", int'(ones_b), m_secs[1] % 10);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_el[k] = 0; m_secs[k] = 0; m_to[k] = 0;
    end
    #1;
    // Reset for two cycles.
    repeat (2) cyc();
    rst_a = 0; rst_b = 0;

    // Full expiry with start held, then retrigger guard.
    start_a = 1;
    cyc();
    check("load_secs", int'(secs_a), 15);
    to_seen_a = 0;
    repeat (59) cyc();
    check("pre_expiry_to", to_seen_a, 0);
    cyc();
    check("expiry_to", int'(to_a), 1);
    check("expiry_secs", int'(secs_a), 0);
    repeat (20) cyc();
    check("guard_single_to", to_seen_a, 1);
    check("guard_secs", int'(secs_a), 0);
    start_a = 0;
    cyc();
    start_a = 1;
    cyc();
    check("reload_secs", int'(secs_a), 15);

    // Early stop 10 cycles after load.
    repeat (9) cyc();
    md_a = 1; start_a = 0;
    cyc();
    md_a = 0;
    check("early_running", int'(run_a), 0);
    check("early_secs", int'(secs_a), 13);
    repeat (5) cyc();
    check("early_hold", int'(secs_a), 13);

    // move_done on the final tick; start dropping mid-turn is ignored.
    start_a = 1;
    cyc();
    start_a = 0;
    to_seen_a = 0;
    repeat (59) cyc();
    md_a = 1;
    cyc();
    md_a = 0;
    check("simul_secs", int'(secs_a), 1);
    check("simul_running", int'(run_a), 0);
    repeat (10) cyc();
    check("simul_no_to", to_seen_a, 0);

    // Reset 30 cycles after load.
    start_a = 1;
    cyc();
    start_a = 0;
    repeat (29) cyc();
    rst_a = 1;
    cyc();
    rst_a = 0;
    check("rst_secs", int'(secs_a), 0);
    check("rst_running", int'(run_a), 0);
    to_seen_a = 0;
    repeat (70) cyc();
    check("rst_no_to", to_seen_a, 0);

    // BCD on the 99-second instance.
    start_b = 1;
    cyc();
    check("bcd99_tens", int'(tens_b), 9);
    check("bcd99_ones", int'(ones_b), 9);
    repeat (4) cyc();
    check("bcd97_tens", int'(tens_b), 9);
    check("bcd97_ones", int'(ones_b), 7);
    repeat (174) cyc();
    check("bcd10_tens", int'(tens_b), 1);
    check("bcd10_ones", int'(ones_b), 0);
    repeat (2) cyc();
    check("bcd09_tens", int'(tens_b), 0);
    check("bcd09_ones", int'(ones_b), 9);
    repeat (20) cyc();

    // Randomized traffic on both instances.
    for (int i = 0; i < 4000; i++) begin
      rst_a = ($urandom_range(0, 299) == 0);
      rst_b = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) start_a = ~start_a;
      if ($urandom_range(0, 19) == 0) start_b = ~start_b;
      md_a = ($urandom_range(0, 79) == 0);
      md_b = ($urandom_range(0, 149) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
